// File: rtl/evt_readout_ctrl.sv
// Readout controller: sequences the pixel arbiter, timestamps granted events and
// buffers them in a first-word-fall-through FIFO behind a valid/ready sink port.
module evt_readout_ctrl #(
    parameter int EVT_W        = 8,
    parameter int TS_W         = 16,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         run_i,
    input  logic                         stop_i,
    output logic                         arb_enable_o,
    input  logic                         arb_gnt_any_i,
    input  logic [EVT_W-1:0]             arb_data_i,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [TS_W+EVT_W-1:0]        evt_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o,
    output logic                         overflow_o,
    output logic [7:0]                   drop_cnt_o,
    output logic [1:0]                   state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int DW    = TS_W + EVT_W;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(DEPTH - AFULL_MARGIN);
    localparam logic [LVL_W-1:0] LVL_HALF  = LVL_W'(DEPTH / 2);

    // state      | meaning
    // S_IDLE     | arbiter off, timestamp held, waiting for run
    // S_RUN      | arbiter enabled, capturing and timestamping
    // S_THROTTLE | FIFO near full, arbiter off, in-flight grants still captured
    // S_DRAIN    | stopped, emptying FIFO before returning to idle
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_THROTTLE = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DW-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [TS_W-1:0]    r_ts;
    logic               r_arb_en;
    logic               r_ovf;
    logic [7:0]         r_drop;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_start;

    assign w_full     = (r_level == LVL_FULL);
    assign w_push_req = (r_state != S_IDLE) && arb_gnt_any_i;
    assign w_pop      = (r_level != '0) && evt_ready_i;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_i && !stop_i) begin
                    w_next  = S_RUN;
                    w_start = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    w_next = S_DRAIN;
                end else if (w_level_nxt >= LVL_AFULL) begin
                    w_next = S_THROTTLE;
                end
            end
            S_THROTTLE: begin
                if (stop_i) begin
                    w_next = S_DRAIN;
                end else if (w_level_nxt <= LVL_HALF) begin
                    w_next = S_RUN;
                end
            end
            S_DRAIN: begin
                if ((w_level_nxt == '0) && !arb_gnt_any_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_arb_en <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ts     <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_state  <= w_next;
            r_arb_en <= (w_next == S_RUN);
            r_level  <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_start) begin
                r_ts <= '0;
            end else if ((r_state == S_RUN) || (r_state == S_THROTTLE)) begin
                r_ts <= r_ts + TS_W'(1);
            end
            if (w_start) begin
                r_ovf  <= 1'b0;
                r_drop <= '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_push) begin
            r_mem[r_wr_ptr] <= {r_ts, arb_data_i};
        end
    end

    assign evt_valid_o  = (r_level != '0);
    assign evt_data_o   = evt_valid_o ? r_mem[r_rd_ptr] : '0;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_ovf;
    assign drop_cnt_o   = r_drop;
    assign arb_enable_o = r_arb_en;
    assign state_o      = r_state;

endmodule

// File: tb/tb_evt_readout_ctrl.sv
// Bench for evt_readout_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_evt_readout_ctrl;

    localparam int EVT_W = 8;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int AFM   = 2;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        run_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        arb_enable_o;
    logic        arb_gnt_any_i = 1'b0;
    logic [7:0]  arb_data_i = 8'h00;
    logic        evt_valid_o;
    logic        evt_ready_i = 1'b0;
    logic [23:0] evt_data_o;
    logic [3:0]  fifo_level_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;
    logic [1:0]  state_o;

    evt_readout_ctrl #(.EVT_W(EVT_W), .TS_W(TS_W), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .run_i(run_i), .stop_i(stop_i),
        .arb_enable_o(arb_enable_o), .arb_gnt_any_i(arb_gnt_any_i), .arb_data_i(arb_data_i),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
        .fifo_level_o(fifo_level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    // Reference model: 0=IDLE 1=RUN 2=THROTTLE 3=DRAIN
    int          m_state = 0;
    int          m_ts    = 0;
    bit          m_ovf   = 1'b0;
    int          m_drop  = 0;
    logic [23:0] m_q[$];
    int          m_nxt;
    bit          m_req;
    bit          m_pop;
    bit          m_full;
    logic [15:0] m_tsv;
    int          m_sz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        if (reset_i) begin
            m_state = 0;
            m_q.delete();
            m_ts   = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_req  = (m_state != 0) && arb_gnt_any_i;
            m_pop  = (m_q.size() != 0) && evt_ready_i;
            m_full = (m_q.size() == DEPTH);
            m_tsv  = m_ts[15:0];
            if (m_pop) void'(m_q.pop_front());
            if (m_req) begin
                if (m_full && !m_pop) begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_q.push_back({m_tsv, arb_data_i});
                end
            end
            m_sz  = m_q.size();
            m_nxt = m_state;
            case (m_state)
                0: if (run_i && !stop_i) m_nxt = 1;
                1: if (stop_i) m_nxt = 3; else if (m_sz >= DEPTH - AFM) m_nxt = 2;
                2: if (stop_i) m_nxt = 3; else if (m_sz <= DEPTH / 2) m_nxt = 1;
                default: if (m_sz == 0 && !arb_gnt_any_i) m_nxt = 0;
            endcase
            if (m_state == 1 || m_state == 2) m_ts = (m_ts + 1) % 65536;
            if (m_state == 0 && m_nxt == 1) begin
                m_ts   = 0;
                m_ovf  = 1'b0;
                m_drop = 0;
            end
            m_state = m_nxt;
        end
    end

    always @(negedge clk_i) begin
        logic [31:0] exp_d;
        if (cmp_en) begin
            exp_d = (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0;
            chk("state", 32'(state_o), 32'(m_state));
            chk("arb_en", 32'(arb_enable_o), (m_state == 1) ? 32'd1 : 32'd0);
            chk("valid", 32'(evt_valid_o), (m_q.size() != 0) ? 32'd1 : 32'd0);
            chk("level", 32'(fifo_level_o), 32'(m_q.size()));
            chk("data", 32'(evt_data_o), exp_d);
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
        end
    end

    task automatic cyc(input bit rst, input bit run, input bit stp, input bit gnt,
                       input logic [7:0] d, input bit rdy);
        reset_i       = rst;
        run_i         = run;
        stop_i        = stp;
        arb_gnt_any_i = gnt;
        arb_data_i    = d;
        evt_ready_i   = rdy;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int guard;
        bit phase;

        cyc(1, 0, 0, 0, 8'h00, 0);
        cmp_en = 1'b1;
        cyc(1, 0, 0, 0, 8'h00, 0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_en", 32'(arb_enable_o), 32'd0);

        // start and three consecutive grants
        cyc(0, 1, 0, 0, 8'h00, 1);
        chk("run_en", 32'(arb_enable_o), 32'd1);
        chk("run_state", 32'(state_o), 32'd1);
        cyc(0, 0, 0, 1, 8'h11, 1);
        chk("ev11", 32'(evt_data_o), 32'h000011);
        cyc(0, 0, 0, 1, 8'h22, 1);
        chk("ev22", 32'(evt_data_o), 32'h000122);
        cyc(0, 0, 0, 1, 8'h33, 1);
        chk("ev33", 32'(evt_data_o), 32'h000233);
        cyc(0, 0, 0, 0, 8'h00, 1);
        chk("ev_empty", 32'(fifo_level_o), 32'd0);
        chk("ev_ovf", 32'(overflow_o), 32'd0);

        // fill to throttle, overflow, full with simultaneous push/pop
        for (int k = 0; k < 11; k++) begin
            cyc(0, 0, 0, 1, 8'(8'h40 + k), 0);
            if (k == 4) begin
                chk("thr_pre_state", 32'(state_o), 32'd1);
                chk("thr_pre_en", 32'(arb_enable_o), 32'd1);
            end
            if (k == 5) begin
                chk("thr_state", 32'(state_o), 32'd2);
                chk("thr_en", 32'(arb_enable_o), 32'd0);
                chk("thr_level", 32'(fifo_level_o), 32'd6);
            end
        end
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_drops", 32'(drop_cnt_o), 32'd3);
        chk("ovf_level", 32'(fifo_level_o), 32'd8);
        chk("ovf_head", 32'(evt_data_o[7:0]), 32'h40);
        cyc(0, 0, 0, 1, 8'h4B, 1);
        chk("full_pp_level", 32'(fifo_level_o), 32'd8);
        chk("full_pp_drops", 32'(drop_cnt_o), 32'd3);
        chk("full_pp_head", 32'(evt_data_o[7:0]), 32'h41);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0, 8'h00, 1);
            if (k == 2) chk("thr_hold", 32'(state_o), 32'd2);
            if (k == 3) begin
                chk("thr_exit_state", 32'(state_o), 32'd1);
                chk("thr_exit_level", 32'(fifo_level_o), 32'd4);
            end
        end

        // stop with 5 queued plus an in-flight grant
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 8'(8'h60 + k), 0);
        cyc(0, 0, 1, 1, 8'h65, 0);
        chk("drain_state", 32'(state_o), 32'd3);
        chk("drain_en", 32'(arb_enable_o), 32'd0);
        chk("drain_level", 32'(fifo_level_o), 32'd6);
        chk("drain_head", 32'(evt_data_o[7:0]), 32'h60);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0, 8'h00, 1);
            if (k == 4) chk("drain_last", 32'(state_o), 32'd3);
        end
        chk("drain_idle", 32'(state_o), 32'd0);
        chk("drain_empty", 32'(fifo_level_o), 32'd0);
        cyc(0, 1, 1, 0, 8'h00, 0);
        chk("idle_runstop", 32'(state_o), 32'd0);
        cyc(0, 1, 0, 0, 8'h00, 0);
        cyc(0, 1, 1, 0, 8'h00, 0);
        chk("run_stop_prio", 32'(state_o), 32'd3);
        cyc(0, 0, 0, 0, 8'h00, 0);
        chk("drain_to_idle", 32'(state_o), 32'd0);

        // reset in the middle of a drain
        cyc(0, 1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 8'(8'h70 + k), 0);
        cyc(0, 0, 1, 0, 8'h00, 0);
        chk("mid_drain_level", 32'(fifo_level_o), 32'd4);
        cyc(1, 0, 0, 0, 8'h00, 1);
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_valid", 32'(evt_valid_o), 32'd0);
        chk("mid_rst_level", 32'(fifo_level_o), 32'd0);
        chk("mid_rst_drops", 32'(drop_cnt_o), 32'd0);

        // randomized traffic with alternating sink pressure
        phase = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) phase = ~phase;
            cyc(($urandom % 400) == 0, ($urandom % 10) == 0, ($urandom % 25) == 0,
                ($urandom % 10) < 6, 8'($urandom),
                phase ? (($urandom % 4) == 0) : (($urandom % 4) != 0));
        end

        // timestamp wrap
        cyc(1, 0, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 0, 8'h00, 0);
        guard = 0;
        while (m_ts != 65535 && guard < 70000) begin
            cyc(0, 0, 0, 0, 8'h00, 1);
            guard++;
        end
        chk("ts_reach_max", 32'(m_ts), 32'd65535);
        cyc(0, 0, 0, 1, 8'hA5, 0);
        chk("ts_max_ev", 32'(evt_data_o), 32'hFFFFA5);
        cyc(0, 0, 0, 1, 8'h5A, 0);
        chk("ts_wrap_level", 32'(fifo_level_o), 32'd2);
        cyc(0, 0, 0, 0, 8'h00, 1);
        chk("ts_wrap_ev", 32'(evt_data_o), 32'h00005A);
        cyc(0, 0, 0, 0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
